seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 185 ++++++++++++++++++
 tb/tb_seq_alu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with single-cycle add/sub/logic and iterative mul/div
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operation handshake (in_ready high only when idle)
//   a, b, cin, op       operands, carry-in (ADD only), opcode
//                       000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 reserved
//   out_valid, out_ready result handshake; outputs hold until taken
//   result, hi          primary result; product high half or remainder
//   flags               {div_zero, overflow, carry, zero}
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [3:0]       flags
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    logic [1:0]       state;
    logic [WIDTH-1:0] b_r;
    logic             is_div;
    logic [CNT_W-1:0] cnt;
    // acc: running product high half (MUL) or partial remainder (DIV)
    // lo:  multiplier shifting out / product low half (MUL), dividend shifting out / quotient (DIV)
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Single-cycle datapath, evaluated straight from the inputs on the accept edge
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] q_hi;
    logic             q_dz;
    logic             q_ov;
    logic             q_c;
    logic [3:0]       q_flags;

    assign add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sub_full = {1'b0, a} - {1'b0, b};

    always_comb begin
        q_res = '0;
        q_hi  = '0;
        q_dz  = 1'b0;
        q_ov  = 1'b0;
        q_c   = 1'b0;
        case (op)
            OP_ADD: begin
                q_res = add_full[WIDTH-1:0];
                q_c   = add_full[WIDTH];
                // overflow only possible when both operands share a sign
                q_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                q_res = sub_full[WIDTH-1:0];
                q_c   = sub_full[WIDTH];
                q_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_DIV: begin
                // only reaches this path when b is zero
                q_res = '1;
                q_hi  = a;
                q_dz  = 1'b1;
            end
            OP_AND: q_res = a & b;
            OP_OR:  q_res = a | b;
            OP_XOR: q_res = a ^ b;
            OP_MUL: q_res = '0;
            default: q_ov = 1'b1;
        endcase
        q_flags = {q_dz, q_ov, q_c, (q_res == '0)};
    end

    // One iteration of shift-add multiply and restoring divide
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_tr;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_lo;
    logic             last_step;

    assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    assign div_sh  = {acc, lo[WIDTH-1]};
    assign div_tr  = div_sh - {1'b0, b_r};

    always_comb begin
        step_acc = '0;
        step_lo  = '0;
        if (is_div) begin
            // a borrow out of the trial subtraction means the divisor did not fit: restore
            step_acc = div_tr[WIDTH] ? div_sh[WIDTH-1:0] : div_tr[WIDTH-1:0];
            step_lo  = {lo[WIDTH-2:0], ~div_tr[WIDTH]};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_lo  = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            b_r    <= '0;
            is_div <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            lo     <= '0;
            result <= '0;
            hi     <= '0;
            flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        b_r    <= b;
                        is_div <= (op == OP_DIV);
                        cnt    <= '0;
                        acc    <= '0;
                        lo     <= a;
                        if ((op == OP_MUL) || ((op == OP_DIV) && (b != '0))) begin
                            state <= CALC;
                        end else begin
                            state  <= DONE;
                            result <= q_res;
                            hi     <= q_hi;
                            flags  <= q_flags;
                        end
                    end
                end
                CALC: begin
                    acc <= step_acc;
                    lo  <= step_lo;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        state  <= DONE;
                        result <= step_lo;
                        hi     <= step_acc;
                        if (is_div) begin
                            flags <= {3'b000, (step_lo == '0)};
                        end else begin
                            flags <= {1'b0, (step_acc != '0), 1'b0, (step_lo == '0)};
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state  <= IDLE;
                        result <= '0;
                        hi     <= '0;
                        flags  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (WIDTH=32)
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] hi;
    logic [3:0]  flags;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [3:0]  fl;
        int          lat;
    } exp_t;

    exp_t sb[$];

    seq_alu #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .hi        (hi),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic [31:0] h, input logic [3:0] f, input int l);
        exp_t e;
        e.res = r; e.hi = h; e.fl = f; e.lat = l;
        return e;
    endfunction

    // Reference model built on wide integer arithmetic
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic c);
        exp_t   e;
        longint sv;
        logic [63:0] p;
        logic dz, ov, cy;
        dz = 0; ov = 0; cy = 0;
        e.res = 0; e.hi = 0; e.lat = 1;
        case (o)
            3'd0: begin
                p = {32'b0, x} + {32'b0, y} + {63'b0, c};
                e.res = p[31:0]; cy = p[32];
                sv = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
                ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
            end
            3'd1: begin
                e.res = x - y; cy = (x < y);
                sv = longint'($signed(x)) - longint'($signed(y));
                ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
            end
            3'd2: begin
                p = {32'b0, x} * {32'b0, y};
                e.res = p[31:0]; e.hi = p[63:32]; ov = (e.hi != 0); e.lat = 33;
            end
            3'd3: begin
                if (y == 0) begin
                    e.res = 32'hFFFFFFFF; e.hi = x; dz = 1;
                end else begin
                    e.res = x / y; e.hi = x % y; e.lat = 33;
                end
            end
            3'd4: e.res = x & y;
            3'd5: e.res = x | y;
            3'd6: e.res = x ^ y;
            default: ov = 1;
        endcase
        e.fl = {dz, ov, cy, (e.res == 0)};
        return e;
    endfunction

    // Called just after a negedge; returns just after a negedge
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic c, input exp_t e, input int hold);
        exp_t got;
        int   lat;
        sb.push_back(e);
        in_valid = 1; op = o; a = x; b = y; cin = c;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 0;
        op  = 3'($urandom_range(0, 7));
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        got = sb.pop_front();
        chk("latency", 64'(lat), 64'(got.lat));
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("result", 64'(result), 64'(got.res));
        chk("hi", 64'(hi), 64'(got.hi));
        chk("flags", 64'(flags), 64'(got.fl));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            op       = 3'($urandom_range(0, 7));
            a        = $urandom;
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_result", 64'(result), 64'(got.res));
            chk("hold_hi_flags", {28'b0, flags, hi}, {28'b0, got.fl, got.hi});
        end
        in_valid  = 0;
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        @(negedge clk);
        chk("post_valid", 64'(out_valid), 64'd0);
        chk("post_in_ready", 64'(in_ready), 64'd1);
        chk("post_outputs", {28'b0, flags, hi}, 64'd0);
        chk("post_result", 64'(result), 64'd0);
    endtask

    initial begin : stim
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic        rc;
        int          seen;

        rst_n = 0; in_valid = 0; out_ready = 0;
        a = 32'hDEADBEEF; b = 32'h12345678; cin = 1; op = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", {28'b0, flags, hi}, 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        rst_n = 1;

        // Directed vectors; the first issues on the very first edge after release
        run_op(3'd0, 32'hFFFFFFFF, 32'h1, 1'b1, mk(32'h1, 32'h0, 4'b0010, 1), 0);
        run_op(3'd1, 32'h80000000, 32'h1, 1'b0, mk(32'h7FFFFFFF, 32'h0, 4'b0100, 1), 0);
        run_op(3'd1, 32'd3, 32'd5, 1'b1, mk(32'hFFFFFFFE, 32'h0, 4'b0010, 1), 0);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, mk(32'h1, 32'hFFFFFFFE, 4'b0100, 33), 0);
        run_op(3'd3, 32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 4'b0000, 33), 0);
        run_op(3'd3, 32'd1234, 32'd0, 1'b0, mk(32'hFFFFFFFF, 32'd1234, 4'b1000, 1), 0);
        run_op(3'd7, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, mk(32'h0, 32'h0, 4'b0101, 1), 0);
        run_op(3'd0, 32'h0, 32'h0, 1'b0, mk(32'h0, 32'h0, 4'b0001, 1), 0);
        run_op(3'd0, 32'h7FFFFFFF, 32'h0, 1'b1, mk(32'h80000000, 32'h0, 4'b0100, 1), 0);
        run_op(3'd2, 32'd12345, 32'd0, 1'b0, mk(32'h0, 32'h0, 4'b0001, 33), 0);
        run_op(3'd3, 32'd5, 32'd9, 1'b0, mk(32'h0, 32'd5, 4'b0001, 33), 0);

        // Backpressure: result must hold for 10 cycles while inputs toggle
        run_op(3'd6, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, model(3'd6, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0), 10);
        run_op(3'd2, 32'h0001FFFF, 32'h00030001, 1'b0, model(3'd2, 32'h0001FFFF, 32'h00030001, 1'b0), 10);

        // Reset during MUL: abandon the operation
        in_valid = 1; op = 3'd2; a = 32'h12345678; b = 32'h9ABCDEF0; cin = 0;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_outputs", {28'b0, flags, hi}, 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_result_after_rst", 64'(seen), 64'd0);

        // Random mix against the model
        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rc = 1'($urandom_range(0, 1));
            run_op(ro, ra, rb, rc, model(ro, ra, rb, rc), 0);
        end
        for (int i = 0; i < 6; i++) begin
            ro = (i % 2 == 0) ? 3'd2 : 3'd3;
            ra = $urandom;
            rb = 32'($urandom_range(1, 65535));
            run_op(ro, ra, rb, 1'b0, model(ro, ra, rb, 1'b0), 0);
        end

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
